// File: rtl/mem_bus_pkg.sv
// Shared constants for the memory-bus responder: region decode values,
// I/O register offsets and CTRL/STATUS bit positions.
package mem_bus_pkg;

  localparam logic [15:0] DEF_IO_BASE = 16'hFF00;
  localparam logic [7:0]  UNMAPPED_RD = 8'hFF;

  localparam logic [2:0] REG_GPIO_OUT = 3'd0;
  localparam logic [2:0] REG_GPIO_IN  = 3'd1;
  localparam logic [2:0] REG_TIMER_LO = 3'd2;
  localparam logic [2:0] REG_TIMER_HI = 3'd3;
  localparam logic [2:0] REG_CMP_LO   = 3'd4;
  localparam logic [2:0] REG_CMP_HI   = 3'd5;
  localparam logic [2:0] REG_CTRL     = 3'd6;
  localparam logic [2:0] REG_STATUS   = 3'd7;

  localparam int CTRL_TEN   = 0;
  localparam int CTRL_IEN   = 1;
  localparam int CTRL_CLR   = 2;
  localparam int STAT_MATCH = 0;
  localparam int STAT_BERR  = 1;

  typedef enum logic [1:0] {
    REGION_RAM,
    REGION_IO,
    REGION_NONE
  } region_e;

endpackage

// File: rtl/mem_bus_responder_io_timer.sv
// Compare timer: free-running counter, byte-writable compare value,
// high-byte shadow for atomic LO/HI reads, and match detection.
module io_timer
  import mem_bus_pkg::*;
#(
  parameter int TIMER_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ten,
  input  logic                   clr_en,
  input  logic                   cmp_lo_we,
  input  logic                   cmp_hi_we,
  input  logic                   lo_read,
  input  logic [7:0]             wdata,
  output logic [7:0]             counter_lo,
  output logic [TIMER_WIDTH-1:0] cmp,
  output logic [7:0]             shadow,
  output logic                   match_pulse
);

  logic [TIMER_WIDTH-1:0] counter;

  // Compare against the current CMP, so a same-cycle CMP write only affects later cycles.
  assign match_pulse = ten & (counter == cmp);
  assign counter_lo  = counter[7:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      counter <= '0;
      cmp     <= '1;
      shadow  <= '0;
    end else begin
      if (ten) begin
        counter <= (match_pulse && clr_en) ? '0 : counter + TIMER_WIDTH'(1);
      end
      if (cmp_lo_we) cmp[7:0] <= wdata;
      if (cmp_hi_we) cmp[TIMER_WIDTH-1:8] <= wdata;
      // Shadow captures the pre-increment high byte alongside the LO read.
      if (lo_read) shadow <= counter[TIMER_WIDTH-1:8];
    end
  end

endmodule

// File: rtl/mem_bus_responder.sv
// Byte-wide memory-bus responder: on-chip RAM, an 8-register I/O window
// (GPIO, compare timer, CTRL/STATUS) and a sticky flag for unmapped accesses.
module mem_bus_responder
  import mem_bus_pkg::*;
#(
  parameter int          RAM_ADDR_WIDTH = 12,
  parameter logic [15:0] IO_BASE        = DEF_IO_BASE,
  parameter int          TIMER_WIDTH    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_rw,
  input  logic [15:0] mem_addr,
  input  logic [7:0]  mem_data,
  output logic [7:0]  mem_Q,
  input  logic [7:0]  gpio_in,
  output logic [7:0]  gpio_out,
  output logic        irq,
  output logic        bus_err
);

  localparam int RAM_DEPTH = 1 << RAM_ADDR_WIDTH;

  logic [7:0]             ram [RAM_DEPTH];
  region_e                region;
  logic [2:0]             offset;
  logic [2:0]             ctrl;
  logic [1:0]             status;
  logic [7:0]             sync1, sync2;
  logic [7:0]             counter_lo, shadow;
  logic [TIMER_WIDTH-1:0] cmp;
  logic                   match_pulse;
  logic                   io_wr, io_rd, status_w1c;
  logic [7:0]             rd_data;

  always_comb begin
    if ((mem_addr >> RAM_ADDR_WIDTH) == 16'd0) region = REGION_RAM;
    else if (mem_addr[15:3] == IO_BASE[15:3])  region = REGION_IO;
    else                                       region = REGION_NONE;
  end

  assign offset     = mem_addr[2:0];
  assign io_wr      = mem_rw && (region == REGION_IO);
  assign io_rd      = !mem_rw && (region == REGION_IO);
  assign status_w1c = io_wr && (offset == REG_STATUS);

  io_timer #(
    .TIMER_WIDTH(TIMER_WIDTH)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .ten        (ctrl[CTRL_TEN]),
    .clr_en     (ctrl[CTRL_CLR]),
    .cmp_lo_we  (io_wr && (offset == REG_CMP_LO)),
    .cmp_hi_we  (io_wr && (offset == REG_CMP_HI)),
    .lo_read    (io_rd && (offset == REG_TIMER_LO)),
    .wdata      (mem_data),
    .counter_lo (counter_lo),
    .cmp        (cmp),
    .shadow     (shadow),
    .match_pulse(match_pulse)
  );

  always_comb begin
    rd_data = UNMAPPED_RD;
    case (region)
      REGION_RAM: rd_data = ram[mem_addr[RAM_ADDR_WIDTH-1:0]];
      REGION_IO: begin
        case (offset)
          REG_GPIO_OUT: rd_data = gpio_out;
          REG_GPIO_IN:  rd_data = sync2;
          REG_TIMER_LO: rd_data = counter_lo;
          REG_TIMER_HI: rd_data = shadow;
          REG_CMP_LO:   rd_data = cmp[7:0];
          REG_CMP_HI:   rd_data = cmp[TIMER_WIDTH-1:8];
          REG_CTRL:     rd_data = {5'd0, ctrl};
          default:      rd_data = {6'd0, status};
        endcase
      end
      default: rd_data = UNMAPPED_RD;
    endcase
  end

  // RAM contents survive reset; only the write is suppressed during it.
  always_ff @(posedge clk) begin
    if (!rst && mem_rw && (region == REGION_RAM)) begin
      ram[mem_addr[RAM_ADDR_WIDTH-1:0]] <= mem_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_Q    <= '0;
      gpio_out <= '0;
      ctrl     <= '0;
      status   <= '0;
      sync1    <= '0;
      sync2    <= '0;
    end else begin
      sync1 <= gpio_in;
      sync2 <= sync1;
      if (!mem_rw) mem_Q <= rd_data;
      if (io_wr && (offset == REG_GPIO_OUT)) gpio_out <= mem_data;
      if (io_wr && (offset == REG_CTRL))     ctrl <= mem_data[CTRL_CLR:CTRL_TEN];
      // Hardware set takes priority over a same-cycle W1C.
      status[STAT_MATCH] <= match_pulse |
                            (status[STAT_MATCH] & ~(status_w1c & mem_data[STAT_MATCH]));
      status[STAT_BERR]  <= (region == REGION_NONE) |
                            (status[STAT_BERR] & ~(status_w1c & mem_data[STAT_BERR]));
    end
  end

  assign irq     = status[STAT_MATCH] & ctrl[CTRL_IEN];
  assign bus_err = status[STAT_BERR];

endmodule

// File: tb/tb_mem_bus_responder.sv
// Bench for mem_bus_responder: directed vector table, hand-written timer/GPIO/reset
// sequences, and randomized traffic checked against a behavioural model.
module tb_mem_bus_responder;

  logic        clk = 1'b0;
  logic        rst, mem_rw, irq, bus_err;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data, mem_Q, gpio_in, gpio_out;

  mem_bus_responder dut (
    .clk     (clk),
    .rst     (rst),
    .mem_rw  (mem_rw),
    .mem_addr(mem_addr),
    .mem_data(mem_data),
    .mem_Q   (mem_Q),
    .gpio_in (gpio_in),
    .gpio_out(gpio_out),
    .irq     (irq),
    .bus_err (bus_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Behavioural model state
  bit [7:0]  m_ram [4096];
  bit        m_rk  [4096];
  bit [7:0]  m_q, m_gpo, m_sh, m_s1, m_s2;
  bit        m_qk;
  bit [2:0]  m_ctrl;
  bit [1:0]  m_st;
  bit [15:0] m_cnt, m_cmp;

  typedef struct {
    logic        w;
    logic [15:0] a;
    logic [7:0]  d;
    logic [7:0]  q;
    logic        b;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic model_edge(input logic r, input logic w, input logic [15:0] a,
                            input logic [7:0] d, input logic [7:0] g);
    bit       in_ram, in_io, unm, match, ten, clr;
    bit [7:0] rv;
    bit       rk;
    if (r) begin
      m_q = 0; m_qk = 1; m_gpo = 0; m_ctrl = 0; m_st = 0;
      m_cnt = 0; m_cmp = 16'hFFFF; m_sh = 0; m_s1 = 0; m_s2 = 0;
      return;
    end
    in_ram = (a < 16'h1000);
    in_io  = !in_ram && (a >= 16'hFF00) && (a <= 16'hFF07);
    unm    = !in_ram && !in_io;
    ten    = m_ctrl[0];
    clr    = m_ctrl[2];
    match  = ten && (m_cnt == m_cmp);
    rv = 8'hFF; rk = 1;
    if (in_ram) begin
      rv = m_ram[a[11:0]]; rk = m_rk[a[11:0]];
    end else if (in_io) begin
      case (a[2:0])
        3'd0: rv = m_gpo;
        3'd1: rv = m_s2;
        3'd2: rv = m_cnt[7:0];
        3'd3: rv = m_sh;
        3'd4: rv = m_cmp[7:0];
        3'd5: rv = m_cmp[15:8];
        3'd6: rv = {5'd0, m_ctrl};
        default: rv = {6'd0, m_st};
      endcase
    end
    if (!w) begin
      m_q = rv; m_qk = rk;
      if (in_io && a[2:0] == 3'd2) m_sh = m_cnt[15:8];
    end else if (in_ram) begin
      m_ram[a[11:0]] = d; m_rk[a[11:0]] = 1;
    end else if (in_io) begin
      case (a[2:0])
        3'd0: m_gpo = d;
        3'd4: m_cmp[7:0] = d;
        3'd5: m_cmp[15:8] = d;
        3'd6: m_ctrl = d[2:0];
        3'd7: m_st = m_st & ~d[1:0];
        default: ;
      endcase
    end
    if (unm) m_st[1] = 1;
    if (match) m_st[0] = 1;
    if (ten) m_cnt = (match && clr) ? 16'd0 : m_cnt + 16'd1;
    m_s2 = m_s1;
    m_s1 = g;
  endtask

  task automatic tick(input logic r, input logic w, input logic [15:0] a,
                      input logic [7:0] d, input logic [7:0] g);
    rst = r; mem_rw = w; mem_addr = a; mem_data = d; gpio_in = g;
    @(posedge clk);
    model_edge(r, w, a, d, g);
    #1;
    if (m_qk) check("model mem_Q", {8'd0, mem_Q}, {8'd0, m_q});
    check("model gpio_out", {8'd0, gpio_out}, {8'd0, m_gpo});
    check("model irq", {15'd0, irq}, {15'd0, m_st[0] & m_ctrl[1]});
    check("model bus_err", {15'd0, bus_err}, {15'd0, m_st[1]});
  endtask

  task automatic add_vec(input logic w, input logic [15:0] a, input logic [7:0] d,
                         input logic [7:0] q, input logic b);
    vec_t v;
    v.w = w; v.a = a; v.d = d; v.q = q; v.b = b;
    tbl.push_back(v);
  endtask

  initial begin
    add_vec(0, 16'hFF04, 8'h00, 8'hFF, 0);
    add_vec(1, 16'h0010, 8'hA5, 8'hFF, 0);
    add_vec(0, 16'h0010, 8'h00, 8'hA5, 0);
    add_vec(0, 16'h9000, 8'h00, 8'hFF, 1);
    add_vec(0, 16'h0010, 8'h00, 8'hA5, 1);
    add_vec(1, 16'hFF07, 8'h02, 8'hA5, 0);
    add_vec(1, 16'hFF00, 8'h81, 8'hA5, 0);
    add_vec(0, 16'hFF00, 8'h00, 8'h81, 0);
    add_vec(1, 16'hFF06, 8'hF8, 8'h81, 0);
    add_vec(0, 16'hFF06, 8'h00, 8'h00, 0);
    add_vec(1, 16'hFF01, 8'h55, 8'h00, 0);
    add_vec(0, 16'hFF05, 8'h00, 8'hFF, 0);
    add_vec(1, 16'h0FFF, 8'h3C, 8'hFF, 0);
    add_vec(0, 16'h0FFF, 8'h00, 8'h3C, 0);
    add_vec(0, 16'h1000, 8'h00, 8'hFF, 1);
    add_vec(1, 16'hFF07, 8'h02, 8'hFF, 0);
    add_vec(1, 16'h1000, 8'h11, 8'hFF, 1);
    add_vec(0, 16'h0010, 8'h00, 8'hA5, 1);
    add_vec(1, 16'hFF07, 8'h02, 8'hA5, 0);
    add_vec(0, 16'hFF07, 8'h00, 8'h00, 0);

    tick(1, 0, 16'h0000, 8'h00, 8'h00);
    tick(1, 0, 16'h0000, 8'h00, 8'h00);
    check("reset mem_Q", {8'd0, mem_Q}, 16'h0000);
    check("reset gpio_out", {8'd0, gpio_out}, 16'h0000);
    check("reset irq/bus_err", {14'd0, irq, bus_err}, 16'h0000);

    foreach (tbl[i]) begin
      tick(0, tbl[i].w, tbl[i].a, tbl[i].d, 8'h00);
      check($sformatf("vec%0d mem_Q", i), {8'd0, mem_Q}, {8'd0, tbl[i].q});
      check($sformatf("vec%0d bus_err", i), {15'd0, bus_err}, {15'd0, tbl[i].b});
    end
    check("gpio_out after write", {8'd0, gpio_out}, 16'h0081);

    // GPIO input synchronizer latency
    tick(0, 0, 16'hFF01, 8'h00, 8'h00);
    tick(0, 0, 16'hFF01, 8'h00, 8'h3C);
    check("gpio_in n", {8'd0, mem_Q}, 16'h0000);
    tick(0, 0, 16'hFF01, 8'h00, 8'h3C);
    check("gpio_in n+1", {8'd0, mem_Q}, 16'h0000);
    tick(0, 0, 16'hFF01, 8'h00, 8'h3C);
    check("gpio_in n+2", {8'd0, mem_Q}, 16'h003C);

    // Match with clear-on-match and interrupt
    tick(0, 1, 16'hFF04, 8'h05, 8'h3C);
    tick(0, 1, 16'hFF05, 8'h00, 8'h3C);
    tick(0, 1, 16'hFF06, 8'h07, 8'h3C);
    for (int k = 1; k <= 6; k++) begin
      tick(0, 0, 16'h0010, 8'h00, 8'h3C);
      check($sformatf("irq k=%0d", k), {15'd0, irq}, (k == 6) ? 16'd1 : 16'd0);
    end
    tick(0, 0, 16'hFF02, 8'h00, 8'h3C);
    check("counter cleared", {8'd0, mem_Q}, 16'h0000);
    tick(0, 1, 16'hFF07, 8'h01, 8'h3C);
    check("irq after W1C", {15'd0, irq}, 16'd0);

    // Reset during a CTRL write; RAM survives
    tick(0, 1, 16'h0020, 8'h5A, 8'h3C);
    tick(0, 0, 16'h0020, 8'h00, 8'h3C);
    tick(1, 1, 16'hFF06, 8'h07, 8'h3C);
    check("rst mem_Q", {8'd0, mem_Q}, 16'h0000);
    check("rst irq", {15'd0, irq}, 16'd0);
    tick(0, 0, 16'hFF06, 8'h00, 8'h3C);
    check("rst CTRL", {8'd0, mem_Q}, 16'h0000);
    tick(0, 0, 16'hFF04, 8'h00, 8'h3C);
    check("rst CMP_LO", {8'd0, mem_Q}, 16'h00FF);
    tick(0, 0, 16'hFF05, 8'h00, 8'h3C);
    check("rst CMP_HI", {8'd0, mem_Q}, 16'h00FF);
    tick(0, 0, 16'h0020, 8'h00, 8'h3C);
    check("RAM kept over reset", {8'd0, mem_Q}, 16'h005A);

    // Atomic LO/HI read around a carry
    tick(0, 1, 16'hFF06, 8'h01, 8'h3C);
    for (int i = 0; i < 16'h12FF; i++) tick(0, 0, 16'h0020, 8'h00, 8'h3C);
    tick(0, 0, 16'hFF02, 8'h00, 8'h3C);
    check("timer lo", {8'd0, mem_Q}, 16'h00FF);
    tick(0, 0, 16'hFF03, 8'h00, 8'h3C);
    check("timer hi shadow", {8'd0, mem_Q}, 16'h0012);
    tick(0, 0, 16'hFF02, 8'h00, 8'h3C);
    check("timer moved on", {8'd0, mem_Q}, 16'h0001);
    tick(0, 1, 16'hFF06, 8'h00, 8'h3C);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] a;
      logic [7:0]  d;
      int          sel;
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2, 3: a = 16'($urandom_range(0, 63));
        4:          a = 16'($urandom_range(16'h0FC0, 16'h0FFF));
        5, 6, 7:    a = 16'hFF00 | 16'($urandom_range(0, 7));
        8:          a = 16'($urandom_range(16'h1000, 16'hFEFF));
        default:    a = 16'($urandom_range(16'hFF08, 16'hFFFF));
      endcase
      d = 8'($urandom);
      if (a == 16'hFF05 && $urandom_range(0, 1) == 1) d = 8'h00;
      if (a == 16'hFF04) d = d & 8'h3F;
      tick(($urandom_range(0, 99) == 0), 1'($urandom), a, d, 8'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
